key_conditioner: RTL and testbench



---
 rtl/key_conditioner.sv | 187 ++++++++++++++++++
 tb/tb_key_conditioner.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Pushbutton front end: synchronise, debounce on a shared tick, emit press pulse/level/long flags.
// Define KEY_AUTOREPEAT_EN to build the REPEAT state and periodic auto-repeat pulses.
module key_conditioner #(
    parameter int NKEY     = 6,
    parameter int TICK_DIV = 50000,
    parameter int DEB_MS   = 20,
    parameter int HOLD_MS  = 800,
    parameter int REP_MS   = 200
) (
    input  logic            CLK_50,
    input  logic            CR,
    input  logic [NKEY-1:0] key_n,
    output logic [NKEY-1:0] key_pulse,
    output logic [NKEY-1:0] key_level,
    output logic [NKEY-1:0] key_long
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [15:0] DEB_LAST  = 16'(DEB_MS - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MS - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [15:0] REP_LAST  = 16'(REP_MS - 1);
`endif

    if (TICK_DIV < 2 || DEB_MS < 2 || HOLD_MS < 2 || REP_MS < 2) begin : g_bad_params
        $error("key_conditioner: TICK_DIV, DEB_MS, HOLD_MS and REP_MS must all be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEB_PRESS,
        S_HELD,
`ifdef KEY_AUTOREPEAT_EN
        S_REPEAT,
`endif
        S_DEB_REL
    } state_t;

    // Shared debounce timebase
    logic [15:0] tick_cnt_reg;
    logic        tick;

    assign tick = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge CLK_50 or posedge CR) begin
        if (CR) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 16'd1;
        end
    end

    // Two-flop synchroniser, idles at "released"
    logic [NKEY-1:0] sync1_reg;
    logic [NKEY-1:0] sync2_reg;

    always_ff @(posedge CLK_50 or posedge CR) begin
        if (CR) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
        end
    end

    for (genvar gi = 0; gi < NKEY; gi++) begin : g_key
        state_t      state_reg, state_next;
        logic [15:0] cnt_reg, cnt_next;
        logic        pulse_reg, pulse_next;
        logic        level_reg, level_next;
        logic        long_reg, long_next;
        logic        pressed;

        assign pressed = ~sync2_reg[gi];

        always_ff @(posedge CLK_50 or posedge CR) begin
            if (CR) begin
                state_reg <= S_IDLE;
                cnt_reg   <= '0;
                pulse_reg <= 1'b0;
                level_reg <= 1'b0;
                long_reg  <= 1'b0;
            end else begin
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
                pulse_reg <= pulse_next;
                level_reg <= level_next;
                long_reg  <= long_next;
            end
        end

        always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            pulse_next = 1'b0;
            long_next  = long_reg;
            case (state_reg)
                S_IDLE: begin
                    long_next = 1'b0;
                    if (pressed) begin
                        state_next = S_DEB_PRESS;
                        cnt_next   = '0;
                    end
                end
                S_DEB_PRESS: begin
                    long_next = 1'b0;
                    if (!pressed) begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                    end else if (tick) begin
                        if (cnt_reg == DEB_LAST) begin
                            state_next = S_HELD;
                            cnt_next   = '0;
                            pulse_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 16'd1;
                        end
                    end
                end
                S_HELD: begin
                    if (!pressed) begin
                        state_next = S_DEB_REL;
                        cnt_next   = '0;
                    end else if (tick) begin
                        if (cnt_reg == HOLD_LAST) begin
                            long_next = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                            state_next = S_REPEAT;
                            cnt_next   = '0;
                            pulse_next = 1'b1;
`endif
                            // Without auto-repeat the count parks at HOLD_LAST
                        end else begin
                            cnt_next = cnt_reg + 16'd1;
                        end
                    end
                end
`ifdef KEY_AUTOREPEAT_EN
                S_REPEAT: begin
                    long_next = 1'b1;
                    if (!pressed) begin
                        state_next = S_DEB_REL;
                        cnt_next   = '0;
                    end else if (tick) begin
                        if (cnt_reg == REP_LAST) begin
                            cnt_next   = '0;
                            pulse_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 16'd1;
                        end
                    end
                end
`endif
                S_DEB_REL: begin
                    // long_reg carries over from the state that released
                    if (pressed) begin
                        state_next = S_HELD;
                        cnt_next   = '0;
                        long_next  = 1'b0;
                    end else if (tick) begin
                        if (cnt_reg == DEB_LAST) begin
                            state_next = S_IDLE;
                            cnt_next   = '0;
                            long_next  = 1'b0;
                        end else begin
                            cnt_next = cnt_reg + 16'd1;
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    long_next  = 1'b0;
                end
            endcase
            level_next = (state_next != S_IDLE) && (state_next != S_DEB_PRESS);
        end

        assign key_pulse[gi] = pulse_reg;
        assign key_level[gi] = level_reg;
        assign key_long[gi]  = long_reg;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random key activity
// compared cycle by cycle with a stability-counting reference model.
module tb_key_conditioner;

    localparam int NKEY     = 6;
    localparam int TICK_DIV = 4;
    localparam int DEB_MS   = 3;
    localparam int HOLD_MS  = 5;
    localparam int REP_MS   = 2;

    logic            clk = 1'b0;
    logic            cr;
    logic [NKEY-1:0] key_n;
    logic [NKEY-1:0] key_pulse;
    logic [NKEY-1:0] key_level;
    logic [NKEY-1:0] key_long;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    key_conditioner #(
        .NKEY    (NKEY),
        .TICK_DIV(TICK_DIV),
        .DEB_MS  (DEB_MS),
        .HOLD_MS (HOLD_MS),
        .REP_MS  (REP_MS)
    ) dut (
        .CLK_50   (clk),
        .CR       (cr),
        .key_n    (key_n),
        .key_pulse(key_pulse),
        .key_level(key_level),
        .key_long (key_long)
    );

    always #5 clk = ~clk;

    // Reference model: a key's accepted level flips once the raw (synchronised) level has
    // disagreed with it for DEB_MS ticks; hold time is counted in ticks while they agree.
    logic [NKEY-1:0] pin_d1, pin_d2;
    bit              lvl        [NKEY];
    bit              dis        [NKEY];
    int              dis_ticks  [NKEY];
    int              hold_ticks [NKEY];
    logic [NKEY-1:0] exp_pulse;
    int              edge_n;

    task automatic model_reset();
        pin_d1    = '1;
        pin_d2    = '1;
        exp_pulse = '0;
        edge_n    = 0;
        for (int i = 0; i < NKEY; i++) begin
            lvl[i]        = 1'b0;
            dis[i]        = 1'b0;
            dis_ticks[i]  = 0;
            hold_ticks[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [NKEY-1:0] kn);
        bit tick;
        bit p;
        tick      = (edge_n % TICK_DIV) == (TICK_DIV - 1);
        exp_pulse = '0;
        for (int i = 0; i < NKEY; i++) begin
            p = ~pin_d2[i];
            if (p != lvl[i]) begin
                if (!dis[i]) begin
                    dis[i]       = 1'b1;
                    dis_ticks[i] = 0;
                end else if (tick) begin
                    dis_ticks[i]++;
                    if (dis_ticks[i] == DEB_MS) begin
                        lvl[i]        = p;
                        dis[i]        = 1'b0;
                        hold_ticks[i] = 0;
                        exp_pulse[i]  = p;
                    end
                end
            end else if (dis[i]) begin
                dis[i]        = 1'b0;
                hold_ticks[i] = 0;
            end else if (lvl[i] && tick) begin
                hold_ticks[i]++;
`ifdef KEY_AUTOREPEAT_EN
                if (hold_ticks[i] >= HOLD_MS && ((hold_ticks[i] - HOLD_MS) % REP_MS) == 0)
                    exp_pulse[i] = 1'b1;
`endif
            end
        end
        pin_d2 = pin_d1;
        pin_d1 = kn;
        edge_n++;
    endtask

    function automatic logic [NKEY-1:0] exp_level();
        logic [NKEY-1:0] v;
        for (int i = 0; i < NKEY; i++) v[i] = lvl[i];
        return v;
    endfunction

    function automatic logic [NKEY-1:0] exp_long();
        logic [NKEY-1:0] v;
        for (int i = 0; i < NKEY; i++) v[i] = lvl[i] && (hold_ticks[i] >= HOLD_MS);
        return v;
    endfunction

    task automatic check_vec(input string tag, input logic [NKEY-1:0] obs, input logic [NKEY-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    task automatic step(input logic [NKEY-1:0] kn);
        key_n = kn;
        @(posedge clk);
        model_edge(kn);
        #1;
        cyc++;
        check_vec("pulse", key_pulse, exp_pulse);
        check_vec("level", key_level, exp_level());
        check_vec("long", key_long, exp_long());
    endtask

    task automatic do_reset(input logic [NKEY-1:0] kn);
        key_n = kn;
        cr    = 1'b1;
        #1;
        model_reset();
        check_vec("rst_async_pulse", key_pulse, '0);
        check_vec("rst_async_level", key_level, '0);
        check_vec("rst_async_long", key_long, '0);
        repeat (3) @(posedge clk);
        #1;
        check_vec("rst_hold_pulse", key_pulse, '0);
        check_vec("rst_hold_level", key_level, '0);
        check_vec("rst_hold_long", key_long, '0);
        cr = 1'b0;
    endtask

    logic [NKEY-1:0] kn;
    int              npulse;
    int              first_at;
    int              long_at;
    int              pulse_cnt [NKEY];
    int              run_left  [NKEY];
    int              pq[$];

    initial begin
        // Reset with key 0 already held: one press pulse within 2+1+12 cycles
        kn    = '1;
        kn[0] = 1'b0;
        do_reset(kn);
        npulse   = 0;
        first_at = -1;
        for (int c = 1; c <= 15; c++) begin
            step(kn);
            if (key_pulse[0]) begin
                npulse++;
                if (first_at < 0) first_at = c;
            end
        end
        check_int("reset_press_pulses", npulse, 1);
        check_int("reset_press_level", int'(key_level[0]), 1);
        $display("txn reset_press: first pulse after %0d cycles", first_at);
        kn = '1;
        repeat (30) step(kn);

        // Bounce on key 1, then stable press: exactly one pulse
        npulse = 0;
        for (int c = 0; c < 60; c++) begin
            kn    = '1;
            kn[1] = ((c / 5) % 2) != 0;
            step(kn);
            if (key_pulse[1]) npulse++;
        end
        check_int("bounce_no_early_pulse", npulse, 0);
        kn    = '1;
        kn[1] = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step(kn);
            if (key_pulse[1]) npulse++;
        end
        check_int("bounce_one_pulse", npulse, 1);
        $display("txn bounce: pulses=%0d", npulse);
        kn = '1;
        repeat (30) step(kn);

        // 3-cycle glitch on key 3 is rejected
        npulse = 0;
        kn[3]  = 1'b0;
        repeat (3) step(kn);
        kn = '1;
        for (int c = 0; c < 30; c++) begin
            step(kn);
            if (key_pulse[3] || key_level[3]) npulse++;
        end
        check_int("glitch_ignored", npulse, 0);
        $display("txn glitch: activity=%0d", npulse);

        // Long hold on key 2 for 100 cycles
        pq.delete();
        long_at = -1;
        kn      = '1;
        kn[2]   = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step(kn);
            if (key_pulse[2]) pq.push_back(c);
            if (key_long[2] && long_at < 0) long_at = c;
        end
`ifdef KEY_AUTOREPEAT_EN
        check_int("hold_enough_pulses", int'(pq.size() >= 3), 1);
        if (pq.size() >= 3) begin
            check_int("hold_first_repeat_gap", pq[1] - pq[0], HOLD_MS * TICK_DIV);
            check_int("hold_next_repeat_gap", pq[2] - pq[1], REP_MS * TICK_DIV);
            check_int("hold_long_from_second", long_at, pq[1]);
        end
`else
        check_int("hold_single_pulse", pq.size(), 1);
        if (pq.size() >= 1)
            check_int("hold_long_delay", long_at - pq[0], HOLD_MS * TICK_DIV);
`endif
        $display("txn hold: pulses=%0d long_at=%0d", pq.size(), long_at);

        // Release with a 4-cycle re-press bounce: no extra pulse, level falls promptly
        npulse = 0;
        kn     = '1;
        repeat (6) step(kn);
        kn[2] = 1'b0;
        repeat (4) step(kn);
        kn       = '1;
        first_at = -1;
        for (int c = 1; c <= 40; c++) begin
            step(kn);
            if (key_pulse[2]) npulse++;
            if (!key_level[2] && first_at < 0) first_at = c;
        end
        check_int("release_no_pulse", npulse, 0);
        check_int("release_fall_in_time", int'(first_at > 0 && first_at <= 2 + 1 + DEB_MS * TICK_DIV), 1);
        $display("txn release: level fell after %0d cycles", first_at);

        // All keys pressed together from a fresh reset
        do_reset('1);
        kn = '1;
        repeat (5) step(kn);
        kn       = '0;
        first_at = -1;
        for (int c = 1; c <= 20; c++) begin
            step(kn);
            if (key_pulse != '0 && first_at < 0) begin
                first_at = c;
                check_vec("simul_all_pulse", key_pulse, '1);
            end
        end
        check_int("simul_pulse_seen", int'(first_at > 0), 1);
        $display("txn simultaneous: first pulse cycle %0d", first_at);

        // Reset while keys are held deep in the hold/repeat phase
        repeat (40) step(kn);
        do_reset(kn);
        for (int i = 0; i < NKEY; i++) pulse_cnt[i] = 0;
        for (int c = 0; c < 16; c++) begin
            step(kn);
            for (int i = 0; i < NKEY; i++) if (key_pulse[i]) pulse_cnt[i]++;
        end
        for (int i = 0; i < NKEY; i++) check_int("post_reset_one_pulse", pulse_cnt[i], 1);
        $display("txn midop_reset: key0 pulses after reset=%0d", pulse_cnt[0]);

        // Random runs of mixed lengths on every key
        kn = '1;
        for (int i = 0; i < NKEY; i++) run_left[i] = $urandom_range(1, 60);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NKEY; i++) begin
                run_left[i]--;
                if (run_left[i] <= 0) begin
                    kn[i]       = ~kn[i];
                    run_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6)
                                                              : $urandom_range(7, 80);
                end
            end
            step(kn);
        end
        $display("txn random: 1500 cycles done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
